// File: rtl/sint_shl_seq.sv
// Sequential signed shift-left: one bit per clock, sticky signed-overflow flag,
// valid/ready handshake on both sides.
module sint_shl_seq #(
  parameter int width = 7
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic [width-1:0] I0,
  input  logic [width-1:0] I1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] O,
  output logic             OVF
);

  localparam int CW = $clog2(width + 1);
  localparam logic [width-1:0] WIDTH_V = width'(width);
  localparam logic [CW-1:0] WIDTH_C = CW'(width);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, next_state;
  logic [width-1:0] data;
  logic [CW-1:0] count;
  logic ovf;
  logic accept;
  logic step;
  logic [CW-1:0] n_load;

  assign accept = (state == IDLE) && in_valid;
  assign step   = (state == SHIFT) && (count != '0);
  // Shifting by width or more always empties the register, so clamp the count.
  assign n_load = (I1 >= WIDTH_V) ? WIDTH_C : I1[CW-1:0];

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) state <= IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = SHIFT;
      SHIFT:   if (count == '0) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      data  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (accept) begin
      data  <= I0;
      count <= n_load;
      ovf   <= 1'b0;
    end else if (step) begin
      data  <= {data[width-2:0], 1'b0};
      count <= count - CW'(1);
      // Sign change between the top two bits means the shifted value left range.
      if (data[width-1] != data[width-2]) ovf <= 1'b1;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign O         = data;
  assign OVF       = ovf;

endmodule

// File: tb/tb_sint_shl_seq.sv
// Scoreboard bench for sint_shl_seq: driver pushes hand-computed results,
// an independent monitor pops and compares when out_valid appears.
module tb_sint_shl_seq;

  localparam int W = 7;

  typedef struct {
    logic [W-1:0] o;
    logic         ovf;
    int           due;
  } exp_t;

  logic CLK = 1'b0;
  logic ASYNCRESET = 1'b1;
  logic [W-1:0] I0 = '0;
  logic [W-1:0] I1 = '0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, OVF;
  logic [W-1:0] O;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  exp_t sb[$];

  sint_shl_seq #(.width(W)) dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET), .I0(I0), .I1(I1),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .O(O), .OVF(OVF)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: pop on the first cycle of each result, then watch it hold until retired.
  bit seen = 0;
  bit retired = 0;
  logic [W-1:0] held_o;
  logic held_ovf;
  always @(negedge CLK) begin
    if (ASYNCRESET) begin
      seen = 0;
      retired = 0;
    end else begin
      if (retired) begin
        checkOutput("ready_after_retire", {31'd0, in_ready}, 32'd1);
        checkOutput("valid_after_retire", {31'd0, out_valid}, 32'd0);
        retired = 0;
      end
      if (out_valid) begin
        if (!seen) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_result", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("result_O", {25'd0, O}, {25'd0, e.o});
            checkOutput("result_OVF", {31'd0, OVF}, {31'd0, e.ovf});
            checkOutput("latency_cycle", cyc, e.due);
          end
          held_o = O;
          held_ovf = OVF;
          seen = 1;
        end else begin
          checkOutput("hold_O", {25'd0, O}, {25'd0, held_o});
          checkOutput("hold_OVF", {31'd0, OVF}, {31'd0, held_ovf});
        end
        checkOutput("in_ready_in_done", {31'd0, in_ready}, 32'd0);
        if (out_ready) begin
          retired = 1;
          seen = 0;
        end
      end
    end
  end

  // Issue one request; inputs are scrambled and in_valid held for one more edge
  // after the accept so that the in-flight operation must ignore them.
  task automatic applyStimulus(input logic [W-1:0] i0, input logic [W-1:0] i1,
                               input logic [W-1:0] exp_o, input logic exp_ovf,
                               input int n, input bit push);
    int tries = 0;
    @(negedge CLK);
    while (!in_ready && tries < 100) begin
      @(negedge CLK);
      tries++;
    end
    if (!in_ready) checkOutput("wait_in_ready_timeout", 32'd0, 32'd1);
    I0 = i0;
    I1 = i1;
    in_valid = 1'b1;
    @(posedge CLK);
    #1;
    if (push) sb.push_back('{o: exp_o, ovf: exp_ovf, due: cyc + n + 1});
    I0 = ~i0;
    I1 = '0;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int tries = 0;
    @(negedge CLK);
    while (!(sb.size() == 0 && !out_valid && in_ready) && tries < 100) begin
      @(negedge CLK);
      tries++;
    end
    if (tries >= 100) checkOutput("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2;
    checkOutput("reset_O", {25'd0, O}, 32'd0);
    checkOutput("reset_OVF", {31'd0, OVF}, 32'd0);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge CLK);
    ASYNCRESET = 1'b0;

    applyStimulus(7'd3,    7'd2,   7'h0C, 1'b0, 2, 1); waitIdle();
    applyStimulus(7'h7D,   7'd1,   7'h7A, 1'b0, 1, 1); waitIdle();
    applyStimulus(7'h20,   7'd1,   7'h40, 1'b1, 1, 1); waitIdle();
    applyStimulus(7'd1,    7'd9,   7'h00, 1'b1, 7, 1); waitIdle();
    applyStimulus(7'd0,    7'd127, 7'h00, 1'b0, 7, 1); waitIdle();
    applyStimulus(7'd5,    7'd0,   7'h05, 1'b0, 0, 1); waitIdle();
    applyStimulus(7'h7F,   7'd3,   7'h78, 1'b0, 3, 1); waitIdle();
    applyStimulus(7'd1,    7'd6,   7'h40, 1'b1, 6, 1); waitIdle();
    applyStimulus(7'd2,    7'd7,   7'h00, 1'b1, 7, 1); waitIdle();

    // Back-pressure: result must hold while the consumer stalls.
    @(posedge CLK); #1;
    out_ready = 1'b0;
    applyStimulus(7'h30, 7'd1, 7'h60, 1'b1, 1, 1);
    for (int t = 0; t < 20 && !out_valid; t++) @(negedge CLK);
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #1;
      in_valid = ~in_valid;
      I0 = I0 + 7'd11;
    end
    @(posedge CLK); #1;
    checkOutput("stall_still_done", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    waitIdle();

    // Reset between edges in the middle of a shift.
    applyStimulus(7'd3, 7'd5, 7'h00, 1'b0, 5, 0);
    @(negedge CLK);
    #2;
    ASYNCRESET = 1'b1;
    #1;
    checkOutput("midrst_O", {25'd0, O}, 32'd0);
    checkOutput("midrst_OVF", {31'd0, OVF}, 32'd0);
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge CLK); #1;
    ASYNCRESET = 1'b0;
    applyStimulus(7'd3, 7'd5, 7'h60, 1'b1, 5, 1); waitIdle();

    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
